reg_writeback: RTL

- Writeback stage directly upstream of the 8-bit accumulator register file.
- Registers execute-stage results and drives the register file's write port: RegWrite, AccWrite, reg_index, writeValue.
- Resolves the dual-write case, where one instruction writes both the accumulator and a general register. It does this by serialising the two writes over two cycles and stalling execute, so the register file never sees AccWrite and RegWrite high together.
- Keeps a retired-instruction counter for debug.

---
 rtl/reg_writeback_if.sv | 32 +++
 rtl/reg_writeback.sv | 107 ++++++++++
 2 files changed

// File: rtl/reg_writeback_if.sv
// Execute-to-writeback handshake and register-file write port bundle.
// slave is the writeback stage; master is the execute/register-file side.
interface reg_writeback_if #(
    parameter int W = 8,
    parameter int D = 4
);
    logic         ex_valid;
    logic         ex_acc_we;
    logic         ex_reg_we;
    logic [D-1:0] ex_reg_index;
    logic [W-1:0] ex_acc_value;
    logic [W-1:0] ex_reg_value;
    logic         ex_stall;
    logic         AccWrite;
    logic         RegWrite;
    logic [D-1:0] reg_index;
    logic [W-1:0] writeValue;

    modport master (
        output ex_valid, ex_acc_we, ex_reg_we,
        output ex_reg_index, ex_acc_value, ex_reg_value,
        input  ex_stall,
        input  AccWrite, RegWrite, reg_index, writeValue
    );

    modport slave (
        input  ex_valid, ex_acc_we, ex_reg_we,
        input  ex_reg_index, ex_acc_value, ex_reg_value,
        output ex_stall,
        output AccWrite, RegWrite, reg_index, writeValue
    );
endinterface

// File: rtl/reg_writeback.sv
// Writeback stage: serialises dual acc+reg writes, counts retired results.
// Define WB_BYPASS_EN to add the fwd_acc_valid/fwd_acc_value bypass outputs.
module reg_writeback #(
    parameter int W  = 8,
    parameter int D  = 4,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          Reset,
    reg_writeback_if.slave wb,
`ifdef WB_BYPASS_EN
    output logic          fwd_acc_valid,
    output logic [W-1:0]  fwd_acc_value,
`endif
    output logic [CW-1:0] retire_count
);
    typedef enum logic {
        IDLE,
        PEND_REG
    } state_t;

    state_t       state_q,  state_d;
    logic         acc_we_q, acc_we_d;
    logic         reg_we_q, reg_we_d;
    logic [D-1:0] idx_q,    idx_d;
    logic [W-1:0] val_q,    val_d;
    logic [D-1:0] pidx_q,   pidx_d;
    logic [W-1:0] pval_q,   pval_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic         accept;

    assign wb.ex_stall = (state_q == PEND_REG);
    assign accept      = wb.ex_valid && !wb.ex_stall;

    always_comb begin
        state_d  = state_q;
        acc_we_d = 1'b0;
        reg_we_d = 1'b0;
        idx_d    = idx_q;
        val_d    = val_q;
        pidx_d   = pidx_q;
        pval_d   = pval_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    if (wb.ex_acc_we) begin
                        acc_we_d = 1'b1;
                        val_d    = wb.ex_acc_value;
                        if (wb.ex_reg_we) begin
                            // Register half waits one cycle behind the acc write.
                            pidx_d  = wb.ex_reg_index;
                            pval_d  = wb.ex_reg_value;
                            state_d = PEND_REG;
                        end
                    end else if (wb.ex_reg_we) begin
                        reg_we_d = 1'b1;
                        idx_d    = wb.ex_reg_index;
                        val_d    = wb.ex_reg_value;
                    end
                end
            end
            PEND_REG: begin
                reg_we_d = 1'b1;
                idx_d    = pidx_q;
                val_d    = pval_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            acc_we_q <= 1'b0;
            reg_we_q <= 1'b0;
            idx_q    <= '0;
            val_q    <= '0;
            pidx_q   <= '0;
            pval_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_we_q <= acc_we_d;
            reg_we_q <= reg_we_d;
            idx_q    <= idx_d;
            val_q    <= val_d;
            pidx_q   <= pidx_d;
            pval_q   <= pval_d;
            cnt_q    <= cnt_d;
        end
    end

    assign wb.AccWrite   = acc_we_q;
    assign wb.RegWrite   = reg_we_q;
    assign wb.reg_index  = idx_q;
    assign wb.writeValue = val_q;
    assign retire_count  = cnt_q;

`ifdef WB_BYPASS_EN
    // A register write to index 0 lands in the accumulator too.
    assign fwd_acc_valid = acc_we_q || (reg_we_q && (idx_q == '0));
    assign fwd_acc_value = val_q;
`endif
endmodule
